// File: rtl/conf_int_mac_pkg.sv
// Shared widths, truncation mask and saturation limits for the configurable-precision MAC.
// Saturating accumulation is selected with the CONF_INT_MAC_SATURATE_EN macro.
package conf_int_mac_pkg;

    localparam int DEF_OP_BITWIDTH        = 32;
    localparam int DEF_DATA_PATH_BITWIDTH = 32;
    localparam int MAX_BITWIDTH           = 64;

    typedef logic [MAX_BITWIDTH-1:0] wide_t;

    // Keeps the top dp bits of an op-bit operand, clears the dropped low bits.
    function automatic wide_t trunc_mask(input int op, input int dp);
        wide_t m;
        m = '0;
        for (int i = 0; i < MAX_BITWIDTH; i++) begin
            if ((i < op) && (i >= (op - dp))) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic wide_t sat_max(input int op);
        wide_t m;
        m = '0;
        for (int i = 0; i < MAX_BITWIDTH; i++) begin
            if (i < (op - 1)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic wide_t sat_min(input int op);
        wide_t m;
        m = '0;
        for (int i = 0; i < MAX_BITWIDTH; i++) begin
            if (i == (op - 1)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam wide_t DEF_SAT_MAX = sat_max(DEF_OP_BITWIDTH);
    localparam wide_t DEF_SAT_MIN = sat_min(DEF_OP_BITWIDTH);

endpackage

// File: rtl/conf_int_mac_core.sv
// Register-free MAC datapath: operand truncation, product, accumulate.
// CONF_INT_MAC_SATURATE_EN selects a clamped accumulate instead of modulo wrap.
module conf_int_mac_core
    import conf_int_mac_pkg::*;
#(
    parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
    input  logic [OP_BITWIDTH-1:0] a_r,
    input  logic [OP_BITWIDTH-1:0] b_r,
    input  logic [OP_BITWIDTH-1:0] acc,
    output logic [OP_BITWIDTH-1:0] acc_next
);

    localparam wide_t                 MASK_WIDE = trunc_mask(OP_BITWIDTH, DATA_PATH_BITWIDTH);
    localparam logic [OP_BITWIDTH-1:0] MASK     = MASK_WIDE[OP_BITWIDTH-1:0];

    logic [OP_BITWIDTH-1:0] a_t_s;
    logic [OP_BITWIDTH-1:0] b_t_s;
    logic [OP_BITWIDTH-1:0] p_s;

    assign a_t_s = a_r & MASK;
    assign b_t_s = b_r & MASK;

    // The low OP_BITWIDTH bits of a two's-complement product do not depend on signedness.
    assign p_s = a_t_s * b_t_s;

`ifdef CONF_INT_MAC_SATURATE_EN
    localparam wide_t                 SAT_MAX_WIDE = sat_max(OP_BITWIDTH);
    localparam wide_t                 SAT_MIN_WIDE = sat_min(OP_BITWIDTH);
    localparam logic [OP_BITWIDTH-1:0] SAT_MAX     = SAT_MAX_WIDE[OP_BITWIDTH-1:0];
    localparam logic [OP_BITWIDTH-1:0] SAT_MIN     = SAT_MIN_WIDE[OP_BITWIDTH-1:0];

    logic [OP_BITWIDTH:0] sum_ext_s;

    assign sum_ext_s = {acc[OP_BITWIDTH-1], acc} + {p_s[OP_BITWIDTH-1], p_s};

    // Clamp when the extra sign bit disagrees with the result sign (signed overflow).
    always_comb begin
        acc_next = sum_ext_s[OP_BITWIDTH-1:0];
        if (sum_ext_s[OP_BITWIDTH] != sum_ext_s[OP_BITWIDTH-1]) begin
            if (sum_ext_s[OP_BITWIDTH]) begin
                acc_next = SAT_MIN;
            end else begin
                acc_next = SAT_MAX;
            end
        end else begin
            acc_next = sum_ext_s[OP_BITWIDTH-1:0];
        end
    end
`else
    // Modulo 2^OP_BITWIDTH accumulate.
    always_comb begin
        acc_next = acc + p_s;
    end
`endif

endmodule

// File: rtl/conf_int_mac_no_ff_arch_agnos_wrapper.sv
// Register wrapper around the combinational MAC core: operand and accumulator registers.
// Build option CONF_INT_MAC_SATURATE_EN (handled in the core) changes wrap to saturation.
module conf_int_mac_no_ff_arch_agnos_wrapper
    import conf_int_mac_pkg::*;
#(
    parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_BITWIDTH-1:0] a,
    input  logic [OP_BITWIDTH-1:0] b,
    output logic [OP_BITWIDTH-1:0] d
);

    if ((DATA_PATH_BITWIDTH > OP_BITWIDTH) || (DATA_PATH_BITWIDTH < 1) ||
        (OP_BITWIDTH > MAX_BITWIDTH)) begin : g_bad_param
        $error("conf_int_mac: illegal OP_BITWIDTH/DATA_PATH_BITWIDTH combination");
    end

    logic [OP_BITWIDTH-1:0] a_r;
    logic [OP_BITWIDTH-1:0] b_r;
    logic [OP_BITWIDTH-1:0] acc_r;
    logic [OP_BITWIDTH-1:0] acc_next_s;

    conf_int_mac_core #(
        .OP_BITWIDTH        (OP_BITWIDTH),
        .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
    ) u_core (
        .a_r      (a_r),
        .b_r      (b_r),
        .acc      (acc_r),
        .acc_next (acc_next_s)
    );

    // Operand capture and accumulation, every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= acc_next_s;
        end
    end

    assign d = acc_r;

endmodule

// File: tb/tb_conf_int_mac_no_ff_arch_agnos_wrapper.sv
// Self-checking bench: full-width and 28-bit-datapath instances driven with the same pairs.
// Expected accumulator values go through a two-deep scoreboard queue matching the MAC latency.
module tb_conf_int_mac_no_ff_arch_agnos_wrapper;

    localparam logic [31:0] M32 = 32'hFFFF_FFFF;
    localparam logic [31:0] M28 = 32'hFFFF_FFF0;

    typedef struct {
        logic        rst_before;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e32;
        logic [31:0] e28;
    } vec_t;

    typedef struct {
        logic [31:0] e32;
        logic [31:0] e28;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d_full;
    logic [31:0] d_trunc;

    int          errors;
    int          checks;
    logic [31:0] m32;
    logic [31:0] m28;
    exp_t        q[$];
    vec_t        tab[5];

    conf_int_mac_no_ff_arch_agnos_wrapper dut_full (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .d   (d_full)
    );

    conf_int_mac_no_ff_arch_agnos_wrapper #(
        .OP_BITWIDTH        (32),
        .DATA_PATH_BITWIDTH (28)
    ) dut_trunc (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .d   (d_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mac_ref(input logic [31:0] acc, input logic [31:0] pa,
                                            input logic [31:0] pb, input logic [31:0] mask);
        logic [31:0] p;
        longint      s;
        p = (pa & mask) * (pb & mask);
`ifdef CONF_INT_MAC_SATURATE_EN
        s = longint'($signed(acc)) + longint'($signed(p));
        if (s > 64'sd2147483647) begin
            s = 64'sd2147483647;
        end else if (s < -64'sd2147483648) begin
            s = -64'sd2147483648;
        end
        return s[31:0];
`else
        s = 0;
        return acc + p;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_t v;
        m32 = 32'h0;
        m28 = 32'h0;
        q.delete();
        v.e32 = 32'h0;
        v.e28 = 32'h0;
        q.push_back(v);
    endtask

    task automatic step_core(input logic [31:0] pa, input logic [31:0] pb, input bit use_tab,
                             input logic [31:0] t32, input logic [31:0] t28);
        exp_t v;
        exp_t e;
        @(negedge clk);
        a = pa;
        b = pb;
        m32 = mac_ref(m32, pa, pb, M32);
        m28 = mac_ref(m28, pa, pb, M28);
        v.e32 = use_tab ? t32 : m32;
        v.e28 = use_tab ? t28 : m28;
        q.push_back(v);
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("d_full", d_full, e.e32);
            check("d_trunc", d_trunc, e.e28);
        end
    endtask

    task automatic step(input logic [31:0] pa, input logic [31:0] pb);
        step_core(pa, pb, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a = 32'h0;
        b = 32'h0;
        #1;
        check("reset_full", d_full, 32'h0);
        check("reset_trunc", d_trunc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a = 32'h0;
        b = 32'h0;
        m32 = 32'h0;
        m28 = 32'h0;

        tab[0] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 32'h0000_0000};
        tab[1] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0002, 32'h0000_0000};
        tab[2] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000};
        tab[3] = '{1'b1, 32'h0000_001F, 32'h0000_0013, 32'h0000_024D, 32'h0000_0100};
        tab[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_024E, 32'h0000_0200};

        // Held reset with random operands keeps d at zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            check("hold_reset_full", d_full, 32'h0);
            check("hold_reset_trunc", d_trunc, 32'h0);
        end
        @(negedge clk);
        a = 32'h0;
        b = 32'h0;
        rst = 1'b0;
        model_clear();
        step(32'h0, 32'h0);
        step(32'h0, 32'h0);

        // Table: basic accumulate, then truncation from reset.
        for (int i = 0; i < 5; i++) begin
            if (tab[i].rst_before) begin
                step(32'h0, 32'h0);
                do_reset();
            end
            step_core(tab[i].a, tab[i].b, 1'b1, tab[i].e32, tab[i].e28);
        end
        step(32'h0, 32'h0);

        // Accumulator overflow boundary.
        do_reset();
        step(32'h7FFF_FFFF, 32'h0000_0001);
        step(32'h0000_0001, 32'h0000_0001);
        step(32'h0, 32'h0);
`ifdef CONF_INT_MAC_SATURATE_EN
        check("overflow_full", d_full, 32'h7FFF_FFFF);
`else
        check("overflow_full", d_full, 32'h8000_0000);
`endif

        // Asynchronous reset pulse between edges in the middle of a stream.
        for (int i = 0; i < 10; i++) begin
            step($urandom_range(1000, 1), $urandom_range(1000, 1));
        end
        rst = 1'b1;
        #1;
        check("midstream_reset_full", d_full, 32'h0);
        check("midstream_reset_trunc", d_trunc, 32'h0);
        #1;
        rst = 1'b0;
        model_clear();
        step(32'h0000_0006, 32'h0000_0007);
        step(32'h0, 32'h0);
        check("after_reset_full", d_full, 32'd42);
        check("after_reset_trunc", d_trunc, 32'h0);

        // Random regression against the reference model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step($urandom, $urandom);
        end
        step(32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
